// File: rtl/mem_port_arbiter_if.sv
// One requester port of the shared data-BRAM: access request plus fixed-latency read return.
// The requester drives master and the arbiter takes slave.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 19
);
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [31:0]       wdata;
  logic [3:0]        wea;
  logic              gnt;
  logic              rvalid;
  logic [31:0]       rdata;

  modport master (
    output req, addr, wdata, wea,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, addr, wdata, wea,
    output gnt, rvalid, rdata
  );
endinterface

// File: rtl/mem_port_arbiter.sv
// Two-port arbiter for the single data-BRAM port: A (exec) normally wins, and B (loader/DMA)
// is forced through after STARVE_MAX refused cycles. Read data is routed back by a tag pipeline.
module mem_port_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int READ_LAT   = 1,
  parameter int STARVE_MAX = 15
) (
  input  logic              clk,
  input  logic              rst,
  mem_port_arbiter_if.slave a,
  mem_port_arbiter_if.slave b,
  output logic              mem_enable,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_wea,
  input  logic [31:0]       mem_rdata
);
  localparam int NUM_PORTS = 2;
  localparam int PA        = 0;
  localparam int PB        = 1;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [31:0]       wdata;
    logic [3:0]        wea;
  } req_t;

  typedef struct packed {
    logic vld;
    logic port;
  } tag_t;

  req_t [NUM_PORTS-1:0] rq;
  req_t                 sel;
  logic [NUM_PORTS-1:0] req;
  logic [NUM_PORTS-1:0] gnt;
  logic [NUM_PORTS-1:0] rvalid;
  logic [NUM_PORTS-1:0][31:0] rdata;
  logic [7:0]           starve_cnt;
  logic                 force_b;
  tag_t [READ_LAT-1:0]  tag_pipe;
  tag_t                 tag_tail;
  logic                 iss_rd;

  assign req[PA] = a.req;
  assign req[PB] = b.req;
  assign rq[PA]  = '{addr: a.addr, wdata: a.wdata, wea: a.wea};
  assign rq[PB]  = '{addr: b.addr, wdata: b.wdata, wea: b.wea};

  assign force_b = (starve_cnt == 8'(STARVE_MAX));

  always_comb begin
    gnt = '0;
    if (!rst) begin
      gnt[PB] = req[PB] && (!req[PA] || force_b);
      gnt[PA] = req[PA] && !gnt[PB];
    end
  end

  assign a.gnt = gnt[PA];
  assign b.gnt = gnt[PB];

  // With no grant the bus idles on A's address/data so only enable and wea need gating.
  assign sel        = gnt[PB] ? rq[PB] : rq[PA];
  assign mem_enable = |gnt;
  assign mem_addr   = sel.addr;
  assign mem_wdata  = sel.wdata;
  assign mem_wea    = mem_enable ? sel.wea : 4'h0;

  always_ff @(posedge clk) begin
    if (rst)
      starve_cnt <= '0;
    else if (req[PB] && !gnt[PB])
      starve_cnt <= force_b ? starve_cnt : starve_cnt + 8'd1;
    else
      starve_cnt <= '0;
  end

  assign iss_rd = mem_enable && (mem_wea == 4'h0);

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_pipe <= '0;
    end else begin
      tag_pipe[0] <= '{vld: iss_rd, port: gnt[PB]};
      for (int i = 1; i < READ_LAT; i++)
        tag_pipe[i] <= tag_pipe[i-1];
    end
  end

  assign tag_tail = tag_pipe[READ_LAT-1];

  // Gated by rst so a read caught in flight never surfaces during the reset cycle itself.
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_ret
    assign rvalid[p] = !rst && tag_tail.vld && (tag_tail.port == 1'(p));
    assign rdata[p]  = rvalid[p] ? mem_rdata : 32'h0;
  end

  assign a.rvalid = rvalid[PA];
  assign a.rdata  = rdata[PA];
  assign b.rvalid = rvalid[PB];
  assign b.rdata  = rdata[PB];
endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: directed scenarios then random traffic, with a
// behavioural BRAM and a rule-level arbitration model.
module tb_mem_port_arbiter;
  localparam int AW    = 19;
  localparam int RL    = 3;
  localparam int SM    = 15;
  localparam int DEPTH = 64;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mem_port_arbiter_if #(.ADDR_W(AW)) a_if ();
  mem_port_arbiter_if #(.ADDR_W(AW)) b_if ();

  logic          mem_enable;
  logic [AW-1:0] mem_addr;
  logic [31:0]   mem_wdata;
  logic [3:0]    mem_wea;
  logic [31:0]   mem_rdata;

  mem_port_arbiter #(.ADDR_W(AW), .READ_LAT(RL), .STARVE_MAX(SM)) dut (
    .clk(clk), .rst(rst), .a(a_if), .b(b_if),
    .mem_enable(mem_enable), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wea(mem_wea), .mem_rdata(mem_rdata)
  );

  function automatic logic [31:0] init_val(int idx);
    if (idx == 16) return 32'hDEADBEEF;
    return (32'(idx) * 32'h01010101) ^ 32'hA5A55A5A;
  endfunction

  function automatic logic [31:0] merge(logic [31:0] old, logic [31:0] wd, logic [3:0] we);
    logic [31:0] r;
    r = old;
    for (int k = 0; k < 4; k++) if (we[k]) r[8*k +: 8] = wd[8*k +: 8];
    return r;
  endfunction

  // Behavioural BRAM: contents start at init_val, read data emerges RL cycles after enable.
  logic [31:0] bram [DEPTH];
  logic        bram_wr [DEPTH];
  logic [31:0] rd_chain [RL];
  assign mem_rdata = rd_chain[RL-1];

  initial for (int i = 0; i < DEPTH; i++) bram_wr[i] = 1'b0;

  always @(posedge clk) begin
    int idx;
    idx = int'(mem_addr[5:0]);
    if (mem_enable) begin
      if (mem_wea != 4'h0) begin
        bram[idx] <= merge(bram_wr[idx] ? bram[idx] : init_val(idx), mem_wdata, mem_wea);
        bram_wr[idx] <= 1'b1;
      end else begin
        rd_chain[0] <= bram_wr[idx] ? bram[idx] : init_val(idx);
      end
    end
    for (int i = 1; i < RL; i++) rd_chain[i] <= rd_chain[i-1];
  end

  int nvec = 0;
  int nerr = 0;
  int cyc  = 0;
  always @(posedge clk) cyc++;

  task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s @cyc %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] data;
    int          due;
  } exp_t;
  exp_t sbq[$];

  // Reference model: shadow memory plus the count of consecutive cycles B has been refused.
  logic [31:0] shadow [DEPTH];
  logic        shadow_wr [DEPTH];
  int          b_wait = 0;
  initial for (int i = 0; i < DEPTH; i++) shadow_wr[i] = 1'b0;

  always @(negedge clk) begin
    logic ea, eb, en;
    logic [AW-1:0] eaddr;
    logic [31:0] ewd, cur;
    logic [3:0] ewe;
    int idx;
    exp_t e;
    if (rst) begin
      sbq.delete();
      b_wait = 0;
      chk("reset_outputs", {a_if.gnt, b_if.gnt, mem_enable, mem_wea, a_if.rvalid, b_if.rvalid},
          {1'b0, 1'b0, 1'b0, 4'h0, 1'b0, 1'b0});
    end else begin
      if (sbq.size() > 0 && sbq[0].due == cyc) begin
        e = sbq.pop_front();
        chk(e.port == 1 ? "b_return" : "a_return",
            {a_if.rvalid, b_if.rvalid, a_if.rdata, b_if.rdata},
            {e.port == 0, e.port == 1, e.port == 0 ? e.data : 32'h0, e.port == 1 ? e.data : 32'h0});
      end else begin
        chk("idle_return", {a_if.rvalid, b_if.rvalid, a_if.rdata, b_if.rdata}, '0);
      end

      eb = b_if.req && (!a_if.req || b_wait == SM);
      ea = a_if.req && !eb;
      en = ea || eb;
      eaddr = eb ? b_if.addr : a_if.addr;
      ewd   = eb ? b_if.wdata : a_if.wdata;
      ewe   = en ? (eb ? b_if.wea : a_if.wea) : 4'h0;
      chk("grant_mem", {a_if.gnt, b_if.gnt, mem_enable, mem_addr, mem_wdata, mem_wea},
          {ea, eb, en, eaddr, ewd, ewe});

      if (en) begin
        idx = int'(eaddr[5:0]);
        cur = shadow_wr[idx] ? shadow[idx] : init_val(idx);
        if (ewe == 4'h0) begin
          sbq.push_back('{port: eb ? 1 : 0, data: cur, due: cyc + RL});
        end else begin
          shadow[idx] = merge(cur, ewd, ewe);
          shadow_wr[idx] = 1'b1;
        end
      end
      b_wait = (b_if.req && !eb) ? ((b_wait < SM) ? b_wait + 1 : SM) : 0;
    end
  end

  task automatic drive(logic ar, logic [AW-1:0] aa, logic [31:0] awd, logic [3:0] awe,
                       logic br, logic [AW-1:0] ba, logic [31:0] bwd, logic [3:0] bwe);
    a_if.req = ar; a_if.addr = aa; a_if.wdata = awd; a_if.wea = awe;
    b_if.req = br; b_if.addr = ba; b_if.wdata = bwd; b_if.wea = bwe;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(int n);
    for (int i = 0; i < n; i++) drive(1'b0, '0, '0, 4'h0, 1'b0, '0, '0, 4'h0);
  endtask

  initial begin
    int bcnt;
    rst = 1'b1;
    drive(1'b1, 19'h4, 32'h0, 4'h0, 1'b1, 19'h8, 32'h0, 4'h0);
    drive(1'b1, 19'h4, 32'h0, 4'h0, 1'b1, 19'h8, 32'h0, 4'h0);
    rst = 1'b0;

    // Continuous contention: B must win exactly on every 16th cycle.
    bcnt = 0;
    for (int i = 1; i <= 40; i++) begin
      drive(1'b1, 19'h4, 32'h0, 4'h0, 1'b1, 19'h8, 32'h0, 4'h0);
    end
    idle(RL + 1);

    drive(1'b0, '0, '0, 4'h0, 1'b1, 19'h10, '0, 4'h0);
    idle(RL + 1);

    drive(1'b1, 19'h4, '0, 4'h0, 1'b0, '0, '0, 4'h0);
    drive(1'b0, '0, '0, 4'h0, 1'b1, 19'h8, '0, 4'h0);
    drive(1'b1, 19'hC, '0, 4'h0, 1'b0, '0, '0, 4'h0);
    idle(RL + 1);

    drive(1'b1, 19'h20, 32'h12345678, 4'hF, 1'b0, '0, '0, 4'h0);
    drive(1'b0, '0, '0, 4'h0, 1'b1, 19'h20, '0, 4'h0);
    idle(RL + 1);

    // B read in flight when reset hits: it must never return.
    drive(1'b0, '0, '0, 4'h0, 1'b1, 19'h10, '0, 4'h0);
    rst = 1'b1;
    idle(1);
    rst = 1'b0;
    idle(RL + 3);

    for (int i = 0; i < 1500; i++) begin
      drive($urandom_range(3) != 0, AW'($urandom_range(DEPTH - 1)), $urandom,
            ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0,
            $urandom_range(1) == 1, AW'($urandom_range(DEPTH - 1)), $urandom,
            ($urandom_range(3) == 0) ? 4'($urandom) : 4'h0);
    end
    idle(RL + 2);

    chk("scoreboard_drained", 128'(sbq.size()), 128'(0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single data-BRAM port between two requesters.
- Port A: exec stage load/store path, normal-priority winner.
- Port B: program loader / debug DMA, low priority with starvation guarantee.
- Tracks in-flight reads through the BRAM read latency and routes read data back to the issuing port.

Parameters:
- ADDR_W, 19, word-address width of the memory port.
- READ_LAT, 1, BRAM read latency in cycles; legal range 1..4.
- STARVE_MAX, 15, cycles B may wait before it is forced to win; legal range 1..255.

Ports:
- clk  in  1  clock, all state on rising edge
- rst  in  1  synchronous active-high reset
- a_req  in  1  A requests an access this cycle
- a_addr  in  ADDR_W  A address
- a_wdata  in  32  A write data
- a_wea  in  4  A byte write enables; 0 = read
- a_gnt  out  1  A access accepted this cycle
- a_rvalid  out  1  A read data valid
- a_rdata  out  32  A read data
- b_req, b_addr, b_wdata, b_wea, b_gnt, b_rvalid, b_rdata  same as A, for port B
- mem_enable  out  1  BRAM enable
- mem_addr  out  ADDR_W  BRAM address
- mem_wdata  out  32  BRAM write data
- mem_wea  out  4  BRAM byte write enables
- mem_rdata  in  32  BRAM read data, READ_LAT cycles after enable

Behaviour:
- Reset: one clock, synchronous, active-high `rst`. While rst=1 or on the cycle it is sampled:
  - a_gnt, b_gnt, mem_enable, a_rvalid, b_rvalid = 0; mem_wea = 0.
  - Starvation counter = 0; read-tag pipeline cleared.
  - Reads in flight at reset are dropped and never return rvalid.
- Arbitration (combinational, same cycle; no request registering):
  - force_b = (starve_cnt == STARVE_MAX).
  - b_gnt = b_req && (!a_req || force_b).
  - a_gnt = a_req && !b_gnt.
  - At most one gnt per cycle. Both idle: mem_enable = 0.
- Memory drive:
  - mem_enable = a_gnt | b_gnt.
  - mem_addr, mem_wdata and mem_wea are muxed from the granted port.
  - When no grant: mem_addr and mem_wdata hold port A values, mem_wea = 0.
- Starvation counter, 8 bits, registered:
  - b_req && !b_gnt: increment, saturating at STARVE_MAX.
  - Otherwise: clear to 0.
  - Consequence: B is granted no later than STARVE_MAX+1 cycles after its first request under continuous A traffic.
  - A refused on a force_b cycle must hold its request (requester's responsibility); the arbiter keeps no A-side state.
- Read-tag pipeline: shift register of READ_LAT entries {valid, port}.
  - Stage 0 loads valid = mem_enable && (mem_wea == 0), port = b_gnt.
  - Shifts every cycle.
  - Writes never produce rvalid.
- Return path:
  - a_rvalid = tail.valid && !tail.port; b_rvalid = tail.valid && tail.port.
  - x_rdata = x_rvalid ? mem_rdata : 32'h0.
  - Fixed latency: rvalid asserts exactly READ_LAT cycles after the granting cycle.
  - Back-to-back reads from alternating ports return in issue order, one per cycle, with no bubbles.
- Write/read same address on consecutive cycles: ordering is the BRAM's (read-first or write-first per BRAM configuration). The arbiter adds no hazard logic.
- No backpressure on the return path: requesters must always accept rvalid.

Test Plan:
- Reset with a_req=b_req=1, wea=0 -> all gnt/rvalid/mem_enable 0. First cycle after rst drops: a_gnt=1, b_gnt=0, starve_cnt counts from 0.
- A idle; B reads addr 0x00010 where mem holds 0xDEADBEEF; READ_LAT=1 -> b_gnt same cycle, mem_addr=0x00010. Next cycle b_rvalid=1, b_rdata=0xDEADBEEF, a_rvalid=0, a_rdata=0.
- a_req and b_req held high continuously, STARVE_MAX=15 -> a_gnt for 15 cycles, b_gnt on cycle 16, a_gnt again on cycle 17. Pattern repeats every 16 cycles.
- Alternating reads A@0x4, B@0x8, A@0xC, READ_LAT=3 -> rvalid on A,B,A exactly 3 cycles after each grant, each carrying its own address's data.
- A writes 0x12345678 wea=4'hf to 0x20, then B reads 0x20 next cycle -> no rvalid for the write. b_rdata=0x12345678 READ_LAT cycles after the read grant.
- B read granted, rst asserted the next cycle (READ_LAT=2) -> no b_rvalid ever appears for that read; outputs return to reset values.
